// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared constants and types for the SPI slave frame front-end.
//            Holds the 2-bit command encodings carried in the top of every
//            frame and the state encoding of the frame FSM.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Command field, frame bits [FRAME_W-1:FRAME_W-2]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shreg.sv
`default_nettype none
// ============================================================================
// Module   : spi_shreg
// Purpose  : Parametrised MSB-first shift register with parallel load.
//            Priority: clr > load > shift. Serial data enters at bit 0 and
//            leaves from bit WIDTH-1.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            clr            - synchronous clear to zero
//            load/load_data - parallel load
//            shift/sin      - shift left by one, sin enters at LSB
//            q              - parallel contents
//            sout           - serial out (current MSB)
// Revision : 1.0 - initial release
// ============================================================================
module spi_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;

    // A one-bit register has nothing to shift up; the new bit simply replaces it.
    generate
        if (WIDTH > 1) begin : g_wide
            assign w_shifted = {r_q[WIDTH-2:0], sin};
        end else begin : g_narrow
            assign w_shifted = sin;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift) begin
            r_q <= w_shifted;
        end
    end

    assign q    = r_q;
    assign sout = r_q[WIDTH-1];

endmodule : spi_shreg
`default_nettype wire

// File: rtl/spi_slave_frame.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_frame
// Purpose  : SPI slave front-end. Deserialises {cmd[1:0], payload} frames
//            from MOSI, strobes rx_valid with the completed frame, and for
//            read-data commands serialises a RAM word onto MISO. Frames are
//            aborted cleanly when SS_n rises early; out-of-order read-data
//            and a missing tx_valid are reported on frame_err.
// Ports    : clk, rst          - system clock, asynchronous active-high reset
//            SS_n, MOSI, MISO  - SPI pins (sampled / driven on clk)
//            rx_data, rx_valid - last completed frame and its strobe
//            tx_data, tx_valid - read word from RAM and its valid level
//            frame_err         - one-cycle error strobe
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err
);

    localparam int c_FRAME_W = DATA_W + 2;
    localparam int c_BCNT_W  = $clog2(c_FRAME_W + 1);
    localparam int c_TCNT_W  = $clog2(TX_TIMEOUT + 1);

    localparam logic [c_BCNT_W-1:0] c_RX_LAST = c_BCNT_W'(c_FRAME_W - 1);
    localparam logic [c_BCNT_W-1:0] c_TX_LAST = c_BCNT_W'(DATA_W - 1);
    localparam logic [c_TCNT_W-1:0] c_TO_LAST = c_TCNT_W'(TX_TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_BCNT_W-1:0]    r_bit_cnt;
    logic [c_BCNT_W-1:0]    w_bit_cnt_next;
    logic [c_TCNT_W-1:0]    r_to_cnt;
    logic [c_TCNT_W-1:0]    w_to_cnt_next;
    logic                   r_rd_pending;
    logic                   w_rd_pending_next;

    logic                   w_rx_shift;
    logic                   w_rx_clr;
    logic                   w_tx_load;
    logic                   w_tx_shift;
    logic                   w_tx_clr;
    logic                   w_rx_fire;
    logic                   w_err;
    logic                   w_miso_next;

    logic [c_FRAME_W-1:0]   w_rx_q;
    logic                   w_rx_sout;
    logic [DATA_W-1:0]      w_tx_q;
    logic                   w_tx_sout;
    logic [c_FRAME_W-1:0]   w_frame;
    logic [1:0]             w_cmd;
    logic                   w_unused_shreg;

    spi_shreg #(
        .WIDTH (c_FRAME_W)
    ) u_rx_shreg (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_rx_clr),
        .load      (1'b0),
        .load_data ({c_FRAME_W{1'b0}}),
        .shift     (w_rx_shift),
        .sin       (MOSI),
        .q         (w_rx_q),
        .sout      (w_rx_sout)
    );

    spi_shreg #(
        .WIDTH (DATA_W)
    ) u_tx_shreg (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_tx_clr),
        .load      (w_tx_load),
        .load_data (tx_data),
        .shift     (w_tx_shift),
        .sin       (1'b0),
        .q         (w_tx_q),
        .sout      (w_tx_sout)
    );

    // Complete frame as it will look once the bit on MOSI now is shifted in;
    // lets rx_data/rx_valid appear in the cycle right after the last bit.
    assign w_frame = {w_rx_q[c_FRAME_W-2:0], MOSI};
    assign w_cmd   = w_frame[c_FRAME_W-1 -: 2];

    // Shift-register taps not needed by this block.
    assign w_unused_shreg = ^{w_rx_q[c_FRAME_W-1], w_rx_sout, w_tx_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_bit_cnt_next    = '0;
        w_to_cnt_next     = '0;
        w_rd_pending_next = r_rd_pending;
        w_rx_shift        = 1'b0;
        w_rx_clr          = 1'b0;
        w_tx_load         = 1'b0;
        w_tx_shift        = 1'b0;
        w_tx_clr          = 1'b0;
        w_rx_fire         = 1'b0;
        w_err             = 1'b0;
        w_miso_next       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The edge that sees SS_n low also captures the first bit.
                if (!SS_n) begin
                    w_state_next   = ST_RX;
                    w_rx_shift     = 1'b1;
                    w_bit_cnt_next = c_BCNT_W'(1);
                end
            end

            ST_RX: begin
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                    w_rx_clr     = 1'b1;
                end else begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == c_RX_LAST) begin
                        w_rx_fire = 1'b1;
                        if (w_cmd == CMD_RD_DATA) begin
                            if (r_rd_pending) begin
                                w_rd_pending_next = 1'b0;
                                w_state_next      = ST_WAIT_TX;
                            end else begin
                                w_err        = 1'b1;
                                w_state_next = ST_DONE;
                            end
                        end else begin
                            if (w_cmd == CMD_RD_ADDR) begin
                                w_rd_pending_next = 1'b1;
                            end
                            w_state_next = ST_DONE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            ST_WAIT_TX: begin
                // tx_valid is checked before the timeout so a word arriving on
                // the final allowed edge is still accepted.
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                end else if (tx_valid) begin
                    w_tx_load    = 1'b1;
                    w_state_next = ST_TX;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_err        = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_to_cnt_next = r_to_cnt + 1'b1;
                end
            end

            ST_TX: begin
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                    w_err        = 1'b1;
                    w_tx_clr     = 1'b1;
                end else begin
                    w_miso_next = w_tx_sout;
                    w_tx_shift  = 1'b1;
                    if (r_bit_cnt == c_TX_LAST) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (SS_n) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_rd_pending <= 1'b0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_bit_cnt    <= w_bit_cnt_next;
            r_to_cnt     <= w_to_cnt_next;
            r_rd_pending <= w_rd_pending_next;
            MISO         <= w_miso_next;
            rx_valid     <= w_rx_fire;
            frame_err    <= w_err;
            if (w_rx_fire) begin
                rx_data <= w_frame;
            end
        end
    end

endmodule : spi_slave_frame
`default_nettype wire

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave front-end between an external SPI master and the single-port RAM controller. It deserialises command+data frames of `2+DATA_W` bits into `rx_data` with a one-cycle `rx_valid` strobe. For read-data commands it serialises a RAM word from `tx_data` back out on MISO. Over the earlier slave it adds:

- Width parametrisation.
- Clean frame abort on SS_n deassertion.
- Read-sequence checking.
- A bounded wait on `tx_valid` with error reporting.

## Interface
Parameters:
- `DATA_W`, 8: payload bits per frame; frame length `FRAME_W = DATA_W+2`.
- `TX_TIMEOUT`, 16: max `clk` cycles waited in WAIT_TX for `tx_valid` (≥1).

Ports:
- `clk` input 1: single system clock; MOSI/SS_n sampled on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `SS_n` input 1: slave select, active-low.
- `MOSI` input 1: serial data in, MSB first.
- `MISO` output 1: serial data out, MSB first.
- `rx_data` output FRAME_W: last completed frame, `{cmd[1:0], payload[DATA_W-1:0]}`.
- `rx_valid` output 1: one-cycle strobe, `rx_data` valid.
- `tx_data` input DATA_W: read word from RAM.
- `tx_valid` input 1: `tx_data` valid (level, sampled).
- `frame_err` output 1: one-cycle strobe on abort, timeout or bad read sequence.

## Operation
- Commands `cmd` = `rx_data[FRAME_W-1:FRAME_W-2]`:
  - 00 write address.
  - 01 write data.
  - 10 read address.
  - 11 read data.
- States:
  - **IDLE**
    - SS_n=0 → RX, and MOSI sampled as bit FRAME_W-1 on that same edge.
  - **RX**
    - Shift one bit per edge while SS_n=0.
    - On the edge sampling bit 0: `rx_data` ← frame, `rx_valid`=1 for one cycle, then:
      - cmd≠11: → DONE. If cmd=10, set `rd_pending`.
      - cmd=11 with `rd_pending`=1: clear `rd_pending`, → WAIT_TX.
      - cmd=11 with `rd_pending`=0: `frame_err` pulse, → DONE. `rx_valid` still fires.
  - **WAIT_TX**
    - Timeout counter counts edges.
    - `tx_valid`=1: capture `tx_data` into TX shift register, → TX.
    - Counter reaches `TX_TIMEOUT` with no `tx_valid`: `frame_err`, → DONE.
  - **TX**
    - MISO = captured word, MSB first, one bit per cycle for DATA_W cycles, → DONE.
    - MOSI is ignored.
  - **DONE**
    - Ignore MOSI until SS_n=1, then → IDLE.
- SS_n=1 observed in RX, WAIT_TX or TX:
  - → IDLE.
  - Partial frame discarded; no `rx_valid`; `frame_err` pulse.
  - `rd_pending` unchanged.
- SS_n=1 in IDLE/DONE: no error.
- `rd_pending` persists across frames; cleared only by accepted read-data or reset.
- MISO=0 in every state except TX.
- Reset mid-frame: immediate return to IDLE; all state discarded.

## Timing
- Reset values:
  - state=IDLE, `rd_pending`=0.
  - MISO=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0.
  - Shift registers and counters 0.
- RX latency: SS_n low at edge 0 (first bit); last bit at edge FRAME_W-1; `rx_valid` high in the cycle after edge FRAME_W-1.
- `rx_data` holds until the next completed frame.
- TX: `tx_valid` sampled high at edge k; MISO = bit DATA_W-1 after edge k+1; bit 0 after edge k+DATA_W; MISO=0 after edge k+DATA_W+1.
- `tx_valid` already high on the first WAIT_TX edge: accepted with zero wait.
- SS_n=1 on the same edge as the last RX bit: abort wins; no `rx_valid`.
- SS_n=1 on the same edge as `tx_valid`: abort wins.
- `frame_err` and `rx_valid` may assert in the same cycle (bad read-data).
- Bit counter width `$clog2(FRAME_W+1)`; timeout counter width `$clog2(TX_TIMEOUT+1)`; no wrap-around is ever reachable.

## Structure
- Package `spi_pkg`:
  - Command constants `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`.
  - State encoding (one-hot localparams or enum) for IDLE, RX, WAIT_TX, TX, DONE.
- Sub-module `spi_shreg`:
  - Parametrised width, MSB-first shift register with `load`, `shift`, `clr`, serial in/out.
  - Instantiated twice: RX with width FRAME_W, TX with width DATA_W.
- Top: FSM, bit/timeout counters, `rd_pending`, output registers.

## Test plan
Run with DATA_W=8, TX_TIMEOUT=16.
1. Write address 0x0A5: SS_n low, MOSI bits `00_10100101` → `rx_data`=0x0A5, `rx_valid` one cycle after edge 9; MISO=0 throughout.
2. Read address 0x2C3, SS_n high, then read data 0x300 with `tx_valid`=1 and `tx_data`=0x5A two cycles after frame end → both `rx_valid` strobes; MISO=0,1,0,1,1,0,1,0 on consecutive cycles; no `frame_err`.
3. Read data 0x3FF with no preceding read address → `rx_valid` and `frame_err` in the same cycle; MISO stays 0.
4. Read address then read data, `tx_valid` held low → `frame_err` exactly 16 cycles after entering WAIT_TX; MISO=0.
5. SS_n raised after 5 bits of a write-data frame → no `rx_valid`; `frame_err` one cycle; the next full frame 0x1FF decodes correctly.
6. `rst` pulsed mid-TX → MISO=0 and `rx_valid`=0 immediately (asynchronous); IDLE; `rd_pending`=0.
